// File: rtl/nios_design_timer_sched_pkg.sv
// rtl/nios_design_timer_sched_pkg.sv - shared constants and FSM state type for the timer scheduler
// Purpose: register map addresses, STATUS bit positions and scan FSM states.
package nios_design_timer_sched_pkg;

    localparam logic [3:0] ADDR_STATUS      = 4'd0;
    localparam logic [3:0] ADDR_CONTROL     = 4'd1;
    localparam logic [3:0] ADDR_MODE        = 4'd2;
    localparam logic [3:0] ADDR_RELOAD_BASE = 4'd4;
    localparam logic [3:0] ADDR_COUNT_BASE  = 4'd8;

    localparam int BUSY_BIT = 14;
    localparam int OVR_BIT  = 15;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/nios_design_timer_sched_regs.sv
// rtl/nios_design_timer_sched_regs.sv - Avalon decode, register file, W1C logic and read mux
// Purpose: holds all software-visible state and merges channel visit results with bus writes.
// Ports:
//   clk, reset                 clock, async active-high reset
//   address/chipselect/write_n/writedata/readdata   Avalon-MM slave
//   busy                       scan in progress (STATUS[14])
//   visit_vld/idx/cnt/exp/dis  visit result for the channel being scanned
//   ovr_set                    tick dropped while one was already pending
//   irq                        combined interrupt
//   count_o/enable_o/mode_o/reload_o  channel state for the shared decrementer
module nios_design_timer_sched_regs
    import nios_design_timer_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     address,
    input  logic                           chipselect,
    input  logic                           write_n,
    input  logic [15:0]                    writedata,
    output logic [15:0]                    readdata,
    input  logic                           busy,
    input  logic                           visit_vld,
    input  logic [1:0]                     visit_idx,
    input  logic [CNT_W-1:0]               visit_cnt,
    input  logic                           visit_exp,
    input  logic                           visit_dis,
    input  logic                           ovr_set,
    output logic                           irq,
    output logic [NUM_CH-1:0][CNT_W-1:0]   count_o,
    output logic [NUM_CH-1:0]              enable_o,
    output logic [NUM_CH-1:0]              mode_o,
    output logic [NUM_CH-1:0][CNT_W-1:0]   reload_o
);

    logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0][CNT_W-1:0] reload_q, reload_d;
    logic [NUM_CH-1:0]            en_q, en_d;
    logic [NUM_CH-1:0]            ien_q, ien_d;
    logic [NUM_CH-1:0]            mode_q, mode_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic                         ovr_q, ovr_d;
    logic [15:0]                  rdata_q, rdata_d;

    logic                         wr;
    logic                         sw_hit;
    logic [NUM_CH-1:0]            pend_set;
    logic [NUM_CH-1:0]            pend_clr;
    logic                         ovr_clr;

    assign wr = chipselect & ~write_n;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        en_d     = en_q;
        ien_d    = ien_q;
        mode_d   = mode_q;
        pend_set = '0;
        pend_clr = '0;
        ovr_clr  = 1'b0;

        // A software write touching the visited channel overrides the visit's
        // count/enable result; the expiry pending set is still honoured.
        sw_hit = wr && ((address == ADDR_CONTROL) ||
                        (address == ADDR_RELOAD_BASE + {2'b00, visit_idx}));

        if (visit_vld && !sw_hit) begin
            count_d[visit_idx] = visit_cnt;
            if (visit_dis) begin
                en_d[visit_idx] = 1'b0;
            end
        end
        if (visit_vld && visit_exp) begin
            pend_set[visit_idx] = 1'b1;
        end

        if (wr) begin
            if (address == ADDR_STATUS) begin
                pend_clr = writedata[NUM_CH-1:0];
                ovr_clr  = writedata[OVR_BIT];
            end
            if (address == ADDR_CONTROL) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (writedata[c] && !en_q[c]) begin
                        count_d[c] = reload_q[c];
                    end
                end
                en_d  = writedata[NUM_CH-1:0];
                ien_d = writedata[8 +: NUM_CH];
            end
            if (address == ADDR_MODE) begin
                mode_d = writedata[NUM_CH-1:0];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (address == ADDR_RELOAD_BASE + 4'(c)) begin
                    reload_d[c] = writedata[CNT_W-1:0];
                    count_d[c]  = writedata[CNT_W-1:0];
                end
            end
        end

        // Hardware set beats a same-cycle software clear.
        pend_d = (pend_q & ~pend_clr) | pend_set;
        ovr_d  = (ovr_q & ~ovr_clr) | ovr_set;

        rdata_d = '0;
        if (address == ADDR_STATUS) begin
            rdata_d[NUM_CH-1:0] = pend_q;
            rdata_d[BUSY_BIT]   = busy;
            rdata_d[OVR_BIT]    = ovr_q;
        end else if (address == ADDR_CONTROL) begin
            rdata_d[NUM_CH-1:0]  = en_q;
            rdata_d[8 +: NUM_CH] = ien_q;
        end else if (address == ADDR_MODE) begin
            rdata_d[NUM_CH-1:0] = mode_q;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (address == ADDR_RELOAD_BASE + 4'(c)) begin
                rdata_d[CNT_W-1:0] = reload_q[c];
            end
            if (address == ADDR_COUNT_BASE + 4'(c)) begin
                rdata_d[CNT_W-1:0] = count_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            en_q     <= '0;
            ien_q    <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            ovr_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            ien_q    <= ien_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(pend_q & ien_q);
    assign count_o  = count_q;
    assign enable_o = en_q;
    assign mode_o   = mode_q;
    assign reload_o = reload_q;

endmodule

// File: rtl/nios_design_timer_sched.sv
// rtl/nios_design_timer_sched.sv - multi-channel software timer scheduler, top level
// Purpose: scan FSM visiting one channel per clock after each tick, shared decrementer.
// Ports: clk, reset (async active-high), tick_in (timebase pulse),
//        address/chipselect/write_n/writedata/readdata (Avalon-MM slave), irq.
module nios_design_timer_sched
    import nios_design_timer_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [1:0] LAST = 2'(NUM_CH - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       tick_pend_q, tick_pend_d;
    logic       ovr_set;

    logic [NUM_CH-1:0][CNT_W-1:0] count;
    logic [NUM_CH-1:0][CNT_W-1:0] reload;
    logic [NUM_CH-1:0]            enable;
    logic [NUM_CH-1:0]            mode;

    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] visit_cnt;
    logic             visit_vld;
    logic             visit_exp;
    logic             visit_dis;

    always_comb begin
        cur_cnt   = count[idx_q];
        visit_vld = (state_q == SCAN) && enable[idx_q];
        visit_exp = visit_vld && (cur_cnt == '0);
        visit_dis = visit_exp && !mode[idx_q];
        // Zero is expiry, so the decrement path never wraps.
        if (cur_cnt == '0) begin
            visit_cnt = mode[idx_q] ? reload[idx_q] : '0;
        end else begin
            visit_cnt = cur_cnt - CNT_W'(1);
        end

        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        ovr_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_in || tick_pend_q) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end
            end
            SCAN: begin
                // One-deep tick queue; a tick arriving on top of it is dropped.
                if (tick_in) begin
                    if (tick_pend_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        tick_pend_d = 1'b1;
                    end
                end
                if (idx_q == LAST) begin
                    idx_d = '0;
                    if (tick_pend_q) begin
                        tick_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    nios_design_timer_sched_regs #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (state_q == SCAN),
        .visit_vld  (visit_vld),
        .visit_idx  (idx_q),
        .visit_cnt  (visit_cnt),
        .visit_exp  (visit_exp),
        .visit_dis  (visit_dis),
        .ovr_set    (ovr_set),
        .irq        (irq),
        .count_o    (count),
        .enable_o   (enable),
        .mode_o     (mode),
        .reload_o   (reload)
    );

endmodule

// File: tb/tb_nios_design_timer_sched.sv
// tb/tb_nios_design_timer_sched.sv - directed self-checking bench for the timer scheduler
module tb_nios_design_timer_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_in = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;

    int tests = 0;
    int failed = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    nios_design_timer_sched #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic tick();
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    initial begin
        // Power-on reset state
        cyc(2);
        chk("por_readdata", readdata, 16'h0000);
        chk("por_irq", {15'd0, irq}, 16'h0000);
        reset = 1'b0;
        cyc(2);

        // 1: reset mid-scan with all channels pending
        wr_reg(4'd4, 16'd0); wr_reg(4'd5, 16'd0); wr_reg(4'd6, 16'd0); wr_reg(4'd7, 16'd0);
        wr_reg(4'd2, 16'h000F);
        wr_reg(4'd1, 16'h0F0F);
        tick();
        cyc(8);
        rd_reg(4'd0, rd);
        chk("t1_pending_all", rd, 16'h000F);
        chk("t1_irq_before", {15'd0, irq}, 16'h0001);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t1_rst_readdata", readdata, 16'h0000);
        chk("t1_rst_irq", {15'd0, irq}, 16'h0000);
        reset = 1'b0;
        rd_reg(4'd0, rd);
        chk("t1_status", rd, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            rd_reg(4'(8 + c), rd);
            chk("t1_count", rd, 16'h0000);
        end
        rd_reg(4'd1, rd);
        chk("t1_control", rd, 16'h0000);

        // 2: periodic ch0, reload 2 -> expires on 3rd tick
        wr_reg(4'd4, 16'd2);
        wr_reg(4'd2, 16'h0001);
        wr_reg(4'd1, 16'h0101);
        tick();
        cyc(20);
        rd_reg(4'd8, rd);
        chk("t2_count_after_1", rd, 16'd1);
        tick();
        cyc(20);
        tick();
        chk("t2_irq_at_T", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        chk("t2_irq_at_T1", {15'd0, irq}, 16'h0001);
        cyc(6);
        rd_reg(4'd0, rd);
        chk("t2_pending0", rd, 16'h0001);
        rd_reg(4'd8, rd);
        chk("t2_count_reloaded", rd, 16'd2);
        wr_reg(4'd0, 16'h0001);
        @(negedge clk);
        chk("t2_irq_cleared", {15'd0, irq}, 16'h0000);
        rd_reg(4'd0, rd);
        chk("t2_status_cleared", rd, 16'h0000);

        // 3: one-shot ch1 with reload 0
        wr_reg(4'd5, 16'd0);
        wr_reg(4'd2, 16'h0000);
        wr_reg(4'd1, 16'h0202);
        tick();
        cyc(8);
        rd_reg(4'd0, rd);
        chk("t3_pending1", rd, 16'h0002);
        rd_reg(4'd1, rd);
        chk("t3_enable_cleared", rd, 16'h0200);
        chk("t3_irq", {15'd0, irq}, 16'h0001);
        tick();
        cyc(8);
        rd_reg(4'd9, rd);
        chk("t3_count_stays", rd, 16'd0);
        rd_reg(4'd0, rd);
        chk("t3_status_stable", rd, 16'h0002);
        rd_reg(4'd1, rd);
        chk("t3_control_stable", rd, 16'h0200);
        wr_reg(4'd0, 16'h0002);

        // 4: back-to-back ticks queue a second scan; a third tick overruns
        wr_reg(4'd2, 16'h0004);
        wr_reg(4'd6, 16'd10);
        wr_reg(4'd1, 16'h0004);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); address = 4'd0;
        @(negedge clk);
        chk("t4_busy_second_scan", readdata, 16'h4000);
        cyc(6);
        rd_reg(4'd0, rd);
        chk("t4_no_overrun", rd, 16'h0000);
        rd_reg(4'd10, rd);
        chk("t4_count_two_scans", rd, 16'd8);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); tick_in = 1'b0;
        cyc(12);
        rd_reg(4'd0, rd);
        chk("t4_overrun", rd, 16'h8000);
        rd_reg(4'd10, rd);
        chk("t4_count_after_ovr", rd, 16'd6);
        wr_reg(4'd0, 16'h8000);
        rd_reg(4'd0, rd);
        chk("t4_overrun_cleared", rd, 16'h0000);

        // 5: RELOAD write during ch2 visit wins over the decrement
        wr_reg(4'd6, 16'd5);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd6; writedata = 16'd100;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        cyc(4);
        rd_reg(4'd10, rd);
        chk("t5_count_sw_wins", rd, 16'd100);
        rd_reg(4'd6, rd);
        chk("t5_reload", rd, 16'd100);

        // 6: expiry beats same-cycle W1C; read latency is one clock
        wr_reg(4'd2, 16'h0008);
        wr_reg(4'd7, 16'd0);
        wr_reg(4'd1, 16'h0808);
        tick();
        cyc(8);
        rd_reg(4'd0, rd);
        chk("t6_pending3", rd, 16'h0008);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd0; writedata = 16'h0008;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        cyc(4);
        @(negedge clk); address = 4'd1;
        @(negedge clk);
        chk("t6_read_control", readdata, 16'h0808);
        address = 4'd0;
        chk("t6_no_early_data", readdata, 16'h0808);
        @(negedge clk);
        chk("t6_pending_kept", readdata, 16'h0008);
        chk("t6_irq", {15'd0, irq}, 16'h0001);
        wr_reg(4'd0, 16'h0008);
        rd_reg(4'd0, rd);
        chk("t6_w1c", rd, 16'h0000);
        chk("t6_irq_cleared", {15'd0, irq}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
